mux_sel_scanner: RTL and testbench



---
 rtl/mux_sel_scanner.sv | 145 ++++++++++++++
 tb/tb_mux_sel_scanner.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_scanner.sv
// Round-robin channel scanner driving a 4:1 mux select; captures y_in at the end of each dwell.
// Optional SCAN_FRAME_EN adds a frame_done pulse on the capture that completes a pass of the mask.
module mux_sel_scanner #(
  parameter int unsigned DIV_N = 4,
  parameter int unsigned W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [3:0]   mask,
  input  logic [W-1:0] y_in,
  output logic [1:0]   sel,
  output logic [W-1:0] dout,
  output logic [1:0]   dout_ch,
  output logic         dout_valid
`ifdef SCAN_FRAME_EN
  ,
  output logic         frame_done
`endif
);

  localparam int unsigned CntW = (DIV_N > 2) ? $clog2(DIV_N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV_N - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StDwell = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [W-1:0]    dout_q, dout_d;
  logic [1:0]      dout_ch_q, dout_ch_d;
  logic            valid_q, valid_d;
  logic            capture;

  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Walk backwards so the nearest channel after c wins; offset 4 wraps to c itself.
  function automatic logic [1:0] next_ch(input logic [1:0] c, input logic [3:0] m);
    logic [1:0] r;
    logic [1:0] k;
    r = c;
    for (int i = 4; i >= 1; i--) begin
      k = c + 2'(i);
      if (m[k]) r = k;
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    dout_d    = dout_q;
    dout_ch_d = dout_ch_q;
    valid_d   = 1'b0;
    capture   = 1'b0;
    case (state_q)
      StIdle: begin
        if (en && (mask != 4'b0000)) begin
          state_d = StDwell;
          sel_d   = lowest_ch(mask);
          cnt_d   = '0;
        end
      end
      default: begin
        if (!en) begin
          // Abort the dwell without capturing; sel and the last sample hold.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          capture   = 1'b1;
          dout_d    = y_in;
          dout_ch_d = sel_q;
          valid_d   = 1'b1;
          cnt_d     = '0;
          if (mask != 4'b0000) begin
            sel_d = next_ch(sel_q, mask);
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sel_q     <= 2'd0;
      dout_q    <= '0;
      dout_ch_q <= 2'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      dout_q    <= dout_d;
      dout_ch_q <= dout_ch_d;
      valid_q   <= valid_d;
    end
  end

  assign sel        = sel_q;
  assign dout       = dout_q;
  assign dout_ch    = dout_ch_q;
  assign dout_valid = valid_q;

`ifdef SCAN_FRAME_EN
  logic frame_q, frame_d;

  function automatic logic [1:0] highest_ch(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // An empty mask has no highest channel, so a capture that empties the scan never ends a frame.
  assign frame_d = capture && (mask != 4'b0000) && (sel_q == highest_ch(mask));

  always_ff @(posedge clk) begin
    if (rst) frame_q <= 1'b0;
    else     frame_q <= frame_d;
  end

  assign frame_done = frame_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Scoreboard bench for mux_sel_scanner: directed scans push expected captures, a monitor checks them.
module tb_mux_sel_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] mask;
  logic [3:0] y_in;
  logic [1:0] sel;
  logic [3:0] dout;
  logic [1:0] dout_ch;
  logic       dout_valid;
`ifdef SCAN_FRAME_EN
  logic       frame_done;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] ch;
    logic [3:0] d;
    logic       fr;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Mux model: each channel carries its index plus 5.
  assign y_in = {2'b00, sel} + 4'h5;

  mux_sel_scanner #(
    .DIV_N(4),
    .W    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mask      (mask),
    .y_in      (y_in),
    .sel       (sel),
    .dout      (dout),
    .dout_ch   (dout_ch),
    .dout_valid(dout_valid)
`ifdef SCAN_FRAME_EN
    ,
    .frame_done(frame_done)
`endif
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_cap(input logic [1:0] ch, input logic [3:0] d, input logic fr);
    exp_t e;
    e.ch = ch;
    e.d  = d;
    e.fr = fr;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", 8'(exp_q.size()), 8'd0);
  endtask

  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 8'(dout_ch), 8'hff);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("cap_ch", 8'(dout_ch), 8'(e.ch));
        chk("cap_data", 8'(dout), 8'(e.d));
`ifdef SCAN_FRAME_EN
        chk("cap_frame", 8'(frame_done), 8'(e.fr));
`endif
      end
    end
`ifdef SCAN_FRAME_EN
    else if (frame_done !== 1'b0) begin
      chk("frame_without_valid", 8'(frame_done), 8'd0);
    end
`endif
  end

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    mask = 4'b0000;
    tick(2);
    chk("rst_sel", 8'(sel), 8'd0);
    chk("rst_dout", 8'(dout), 8'd0);
    chk("rst_dout_ch", 8'(dout_ch), 8'd0);
    chk("rst_valid", 8'(dout_valid), 8'd0);
    rst = 1'b0;

    // Full mask: captures in cycles 5, 9, 13, 17 on channels 0..3.
    mask = 4'b1111;
    en   = 1'b1;
    expect_cap(2'd0, 4'd5, 1'b0);
    expect_cap(2'd1, 4'd6, 1'b0);
    expect_cap(2'd2, 4'd7, 1'b0);
    expect_cap(2'd3, 4'd8, 1'b1);
    tick(1);
    chk("p1_sel_start", 8'(sel), 8'd0);
    tick(3);
    chk("p1_no_early_valid", 8'(dout_valid), 8'd0);
    tick(1);
    chk("p1_first_valid", 8'(dout_valid), 8'd1);
    chk("p1_sel_step", 8'(sel), 8'd1);
    tick(12);
    chk("p1_last_valid", 8'(dout_valid), 8'd1);
    chk("p1_sel_wrap", 8'(sel), 8'd0);
    en = 1'b0;
    tick(1);
    drain();
    chk("p1_dout_hold", 8'(dout), 8'd8);
    chk("p1_dout_ch_hold", 8'(dout_ch), 8'd3);

    // Sparse mask 1010: alternates 1, 3.
    mask = 4'b1010;
    en   = 1'b1;
    expect_cap(2'd1, 4'd6, 1'b0);
    expect_cap(2'd3, 4'd8, 1'b1);
    expect_cap(2'd1, 4'd6, 1'b0);
    expect_cap(2'd3, 4'd8, 1'b1);
    tick(1);
    chk("p2_sel_start", 8'(sel), 8'd1);
    tick(16);
    chk("p2_sel_wrap", 8'(sel), 8'd1);
    en = 1'b0;
    tick(1);
    drain();

    // Single channel: sel stays at 2.
    mask = 4'b0100;
    en   = 1'b1;
    expect_cap(2'd2, 4'd7, 1'b1);
    expect_cap(2'd2, 4'd7, 1'b1);
    expect_cap(2'd2, 4'd7, 1'b1);
    tick(13);
    chk("p3_sel_stuck", 8'(sel), 8'd2);
    en = 1'b0;
    tick(1);
    drain();

    // en dropped on the cnt==3 edge: no capture, sel held at 2.
    mask = 4'b1100;
    en   = 1'b1;
    tick(4);
    en = 1'b0;
    tick(1);
    chk("p4_abort_valid", 8'(dout_valid), 8'd0);
    chk("p4_abort_sel", 8'(sel), 8'd2);
    tick(3);
    chk("p4_idle_valid", 8'(dout_valid), 8'd0);

    // Re-enable with 0110 restarts at channel 1.
    mask = 4'b0110;
    en   = 1'b1;
    expect_cap(2'd1, 4'd6, 1'b0);
    tick(1);
    chk("p4_restart_sel", 8'(sel), 8'd1);
    tick(3);
    chk("p4_no_early_valid", 8'(dout_valid), 8'd0);
    tick(1);
    chk("p4_first_valid", 8'(dout_valid), 8'd1);
    chk("p4_sel_next", 8'(sel), 8'd2);

    // Mask cleared mid-dwell on channel 2: that dwell still completes, then idle.
    expect_cap(2'd2, 4'd7, 1'b0);
    tick(1);
    mask = 4'b0000;
    tick(3);
    chk("p5_final_valid", 8'(dout_valid), 8'd1);
    tick(8);
    chk("p5_idle_sel", 8'(sel), 8'd2);
    chk("p5_idle_valid", 8'(dout_valid), 8'd0);
    drain();

    // Reset on the capture edge of channel 3: the capture is lost.
    mask = 4'b1000;
    tick(1);
    chk("p6_sel_start", 8'(sel), 8'd3);
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("p6_rst_sel", 8'(sel), 8'd0);
    chk("p6_rst_dout", 8'(dout), 8'd0);
    chk("p6_rst_dout_ch", 8'(dout_ch), 8'd0);
    chk("p6_rst_valid", 8'(dout_valid), 8'd0);
    rst = 1'b0;
    en  = 1'b0;
    tick(6);
    chk("p6_post_valid", 8'(dout_valid), 8'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
